// File: rtl/mem_lsu.sv
// mem_lsu: load/store initiator for a 256-word synchronous memory with range-checked requests
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req_valid/o_req_ready    request handshake (ready only in IDLE, registered)
//   i_req_we, i_req_addr       1 = write / 0 = read, word start address
//   i_req_wdata, i_req_len     write data, burst length minus 1 (reads only)
//   o_rsp_valid/_rdata/_last   response beat, read data (0 for write/error), final beat
//   o_rsp_err                  request rejected by range check
//   o_mem_addr/_wdata/_we      memory port
//   i_mem_rdata                memory read data, one cycle after o_mem_addr
module mem_lsu #(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [15:0] i_req_addr,
   input  logic [15:0] i_req_wdata,
   input  logic [3:0]  i_req_len,
   output logic        o_rsp_valid,
   output logic [15:0] o_rsp_rdata,
   output logic        o_rsp_last,
   output logic        o_rsp_err,
   output logic [15:0] o_mem_addr,
   output logic [15:0] o_mem_wdata,
   output logic        o_mem_we,
   input  logic [15:0] i_mem_rdata
);
   typedef enum logic [2:0] {IDLE, READ, WRITE, ERR, DRAIN} state_t;
   state_t      r_state;
   logic        r_req_ready, r_rsp_valid, r_rsp_last, r_rsp_err, r_rd_beat, r_mem_we;
   logic [15:0] r_mem_addr, r_mem_wdata;
   logic [3:0]  r_cnt;
   logic [16:0] w_end;
   logic        w_err, w_accept;
   assign w_accept = i_req_valid && r_req_ready;
   // 17-bit sum so an address near 0xFFFF cannot wrap back into range
   assign w_end = {1'b0, i_req_addr} + (i_req_we ? 17'd0 : {13'd0, i_req_len});
   assign w_err = w_end >= 17'(MEM_WORDS);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_last  <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rd_beat   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cnt       <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_last  <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rd_beat   <= 1'b0;
         r_mem_we    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_req_ready <= 1'b0;
                  if (w_err) begin
                     r_state     <= ERR;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_last  <= 1'b1;
                  end else if (i_req_we) begin
                     r_state     <= WRITE;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= i_req_addr;
                     r_mem_wdata <= i_req_wdata;
                  end else begin
                     r_state    <= READ;
                     r_mem_addr <= i_req_addr;
                     r_cnt      <= i_req_len;
                  end
               end else begin
                  r_req_ready <= 1'b1;
               end
            end
            // each issue cycle schedules the matching response beat one cycle later
            READ: begin
               r_rsp_valid <= 1'b1;
               r_rd_beat   <= 1'b1;
               r_rsp_last  <= (r_cnt == 4'd0);
               if (r_cnt == 4'd0) begin
                  r_state <= DRAIN;
               end else begin
                  r_mem_addr <= r_mem_addr + 16'd1;
                  r_cnt      <= r_cnt - 4'd1;
               end
            end
            WRITE: begin
               r_rsp_valid <= 1'b1;
               r_rsp_last  <= 1'b1;
               r_state     <= DRAIN;
            end
            default: begin
               r_state     <= IDLE;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end
   assign o_req_ready = r_req_ready;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_last  = r_rsp_last;
   assign o_rsp_err   = r_rsp_err;
   assign o_rsp_rdata = r_rd_beat ? i_mem_rdata : 16'd0;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_we    = r_mem_we;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu with a 256x16 synchronous memory model
module tb_mem_lsu;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req_valid = 1'b0, i_req_we = 1'b0;
   logic [15:0] i_req_addr = '0, i_req_wdata = '0;
   logic [3:0]  i_req_len = '0;
   logic        o_req_ready, o_rsp_valid, o_rsp_last, o_rsp_err, o_mem_we;
   logic [15:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
   logic [15:0] mem_rdata;
   logic [15:0] mem [256];
   logic [15:0] exp_mem [256];
   int checks = 0, failures = 0;
   logic        c_v [1:24], c_l [1:24], c_e [1:24], c_r [1:24], c_we [1:24];
   logic [15:0] c_d [1:24], c_a [1:24], c_wd [1:24];

   mem_lsu dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_len(i_req_len),
      .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_last(o_rsp_last), .o_rsp_err(o_rsp_err),
      .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .i_mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'd0;
      end else if (o_mem_we) begin
         mem[o_mem_addr[7:0]] <= o_mem_wdata;
      end
      mem_rdata <= mem[o_mem_addr[7:0]];
   end

   task automatic send(input logic we, input logic [15:0] a, input logic [15:0] d, input logic [3:0] len);
      int t = 0;
      i_req_valid = 1'b1; i_req_we = we; i_req_addr = a; i_req_wdata = d; i_req_len = len;
      while (!o_req_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (!o_req_ready) begin
         checks++; failures++;
         $display("FAIL send_timeout ready=%0b required=1", o_req_ready);
      end
      @(posedge clk); #1;
      i_req_valid = 1'b0;
      if (we && a < 16'd256) exp_mem[a[7:0]] = d;
   endtask

   task automatic capture(input int n);
      for (int c = 1; c <= n; c++) begin
         c_v[c] = o_rsp_valid; c_l[c] = o_rsp_last; c_e[c] = o_rsp_err; c_r[c] = o_req_ready;
         c_we[c] = o_mem_we; c_d[c] = o_rsp_rdata; c_a[c] = o_mem_addr; c_wd[c] = o_mem_wdata;
         if (c < n) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic do_write(input logic [15:0] a, input logic [15:0] d);
      send(1'b1, a, d, 4'd0);
      capture(3);
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({o_req_ready, o_rsp_valid, o_rsp_last, o_rsp_err, o_rsp_rdata, o_mem_addr, o_mem_wdata, o_mem_we} !== 53'd0) begin
         failures++;
         $display("FAIL reset_outputs got ready=%0b valid=%0b addr=%h we=%0b required all 0", o_req_ready, o_rsp_valid, o_mem_addr, o_mem_we);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (o_req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_before_edge got=%0b required=0", o_req_ready); end
      @(posedge clk); #1;
      checks++;
      if (o_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after_edge got=%0b required=1", o_req_ready); end
   endtask

   task automatic test_write_read;
      int n_we = 0;
      send(1'b1, 16'h0010, 16'hBEEF, 4'd0);
      capture(4);
      for (int c = 1; c <= 4; c++) n_we += int'(c_we[c]);
      checks++;
      if (n_we != 1 || c_we[1] !== 1'b1) begin failures++; $display("FAIL write_we_cycles got=%0d we1=%0b required=1 in cycle 1", n_we, c_we[1]); end
      checks++;
      if ({c_a[1], c_wd[1]} !== {16'h0010, 16'hBEEF}) begin failures++; $display("FAIL write_port got addr=%h data=%h required 0010 BEEF", c_a[1], c_wd[1]); end
      checks++;
      if ({c_v[1], c_v[2], c_l[2], c_e[2], c_d[2], c_v[3]} !== {1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0}) begin
         failures++; $display("FAIL write_rsp got v1=%0b v2=%0b l=%0b e=%0b d=%h v3=%0b", c_v[1], c_v[2], c_l[2], c_e[2], c_d[2], c_v[3]);
      end
      checks++;
      if ({c_r[2], c_r[3]} !== 2'b01) begin failures++; $display("FAIL write_ready got c2=%0b c3=%0b required 0 1", c_r[2], c_r[3]); end
      send(1'b0, 16'h0010, 16'h0000, 4'd0);
      capture(3);
      checks++;
      if ({c_v[1], c_a[1]} !== {1'b0, 16'h0010}) begin failures++; $display("FAIL read_issue got v=%0b addr=%h required 0 0010", c_v[1], c_a[1]); end
      checks++;
      if ({c_v[2], c_l[2], c_e[2], c_d[2]} !== {1'b1, 1'b1, 1'b0, 16'hBEEF}) begin
         failures++; $display("FAIL read_after_write got v=%0b l=%0b e=%0b d=%h required 1 1 0 BEEF", c_v[2], c_l[2], c_e[2], c_d[2]);
      end
      checks++;
      if ({c_v[3], c_r[3]} !== 2'b01) begin failures++; $display("FAIL read_single_end got v=%0b ready=%0b required 0 1", c_v[3], c_r[3]); end
   endtask

   task automatic test_burst;
      logic [18:0] got, want;
      do_write(16'h0020, 16'h1111);
      do_write(16'h0021, 16'h2222);
      do_write(16'h0022, 16'h3333);
      do_write(16'h0023, 16'h4444);
      send(1'b0, 16'h0020, 16'h0000, 4'd3);
      capture(6);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (c_a[k+1] !== 16'h0020 + 16'(k)) begin failures++; $display("FAIL burst_addr k=%0d got=%h required=%h", k, c_a[k+1], 16'h0020 + 16'(k)); end
      end
      for (int c = 1; c <= 6; c++) begin
         got = {c_v[c], c_l[c], c_e[c], c_d[c]};
         want = {c >= 2 && c <= 5, c == 5, 1'b0, (c >= 2 && c <= 5) ? exp_mem[8'h20 + 8'(c - 2)] : 16'h0000};
         checks++;
         if (got !== want) begin failures++; $display("FAIL burst_beat cycle=%0d got=%h required=%h", c, got, want); end
      end
      checks++;
      if ({c_r[5], c_r[6]} !== 2'b01) begin failures++; $display("FAIL burst_ready got c5=%0b c6=%0b required 0 1", c_r[5], c_r[6]); end
   endtask

   task automatic test_range;
      int beats, errs;
      do_write(16'h00FC, 16'hF0C0);
      do_write(16'h00FD, 16'hF0C1);
      do_write(16'h00FE, 16'hF0C2);
      send(1'b1, 16'h00FF, 16'hF0C3, 4'd0);
      capture(3);
      checks++;
      if ({c_we[1], c_a[1], c_v[2], c_e[2]} !== {1'b1, 16'h00FF, 1'b1, 1'b0}) begin
         failures++; $display("FAIL write_00ff got we=%0b addr=%h v=%0b e=%0b required 1 00FF 1 0", c_we[1], c_a[1], c_v[2], c_e[2]);
      end
      send(1'b0, 16'h00FC, 16'h0000, 4'd3);
      capture(6);
      beats = 0; errs = 0;
      for (int c = 1; c <= 6; c++) begin
         beats += int'(c_v[c]); errs += int'(c_e[c]);
         if (c >= 2 && c <= 5) begin
            checks++;
            if (c_d[c] !== 16'hF0C0 + 16'(c - 2)) begin failures++; $display("FAIL read_00fc_data cycle=%0d got=%h required=%h", c, c_d[c], 16'hF0C0 + 16'(c - 2)); end
         end
      end
      checks++;
      if (beats != 4 || errs != 0) begin failures++; $display("FAIL read_00fc_beats got beats=%0d errs=%0d required 4 0", beats, errs); end
      send(1'b0, 16'h00FD, 16'h0000, 4'd3);
      capture(2);
      checks++;
      if ({c_v[1], c_l[1], c_e[1], c_d[1], c_we[1], c_a[1], c_v[2], c_r[2]} !== {1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h00FF, 1'b0, 1'b1}) begin
         failures++; $display("FAIL read_00fd_err got v=%0b l=%0b e=%0b d=%h we=%0b addr=%h v2=%0b r2=%0b", c_v[1], c_l[1], c_e[1], c_d[1], c_we[1], c_a[1], c_v[2], c_r[2]);
      end
      send(1'b0, 16'hFFFF, 16'h0000, 4'd15);
      capture(2);
      checks++;
      if ({c_v[1], c_e[1], c_l[1], c_we[1], c_a[1], c_v[2]} !== {1'b1, 1'b1, 1'b1, 1'b0, 16'h00FF, 1'b0}) begin
         failures++; $display("FAIL read_ffff_err got v=%0b e=%0b l=%0b we=%0b addr=%h v2=%0b", c_v[1], c_e[1], c_l[1], c_we[1], c_a[1], c_v[2]);
      end
      send(1'b1, 16'h0100, 16'hDEAD, 4'd0);
      capture(2);
      checks++;
      if ({c_v[1], c_e[1], c_l[1], c_we[1], c_we[2], c_a[1], c_r[2]} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00FF, 1'b1}) begin
         failures++; $display("FAIL write_0100_err got v=%0b e=%0b l=%0b we=%0b%0b addr=%h r2=%0b", c_v[1], c_e[1], c_l[1], c_we[1], c_we[2], c_a[1], c_r[2]);
      end
   endtask

   task automatic test_backpressure;
      logic [18:0] got, want;
      send(1'b0, 16'h0020, 16'h0000, 4'd15);
      i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 16'h0030; i_req_wdata = 16'hA5A5; i_req_len = 4'd7;
      for (int c = 1; c <= 21; c++) begin
         if (c <= 18) begin
            checks++;
            if ({o_req_ready, o_mem_we} !== {c == 18, 1'b0}) begin failures++; $display("FAIL bp_ready cycle=%0d got ready=%0b we=%0b", c, o_req_ready, o_mem_we); end
            got = {o_rsp_valid, o_rsp_last, o_rsp_err, o_rsp_rdata};
            want = {c >= 2 && c <= 17, c == 17, 1'b0, (c >= 2 && c <= 17) ? exp_mem[8'h20 + 8'(c - 2)] : 16'h0000};
            checks++;
            if (got !== want) begin failures++; $display("FAIL bp_beat cycle=%0d got=%h required=%h", c, got, want); end
         end
         if (c == 19) begin
            checks++;
            if ({o_mem_we, o_mem_addr, o_mem_wdata} !== {1'b1, 16'h0030, 16'hA5A5}) begin
               failures++; $display("FAIL bp_second_accept got we=%0b addr=%h data=%h required 1 0030 A5A5", o_mem_we, o_mem_addr, o_mem_wdata);
            end
            i_req_valid = 1'b0;
            exp_mem[8'h30] = 16'hA5A5;
         end
         if (c == 20) begin
            checks++;
            if ({o_rsp_valid, o_rsp_last, o_rsp_err, o_mem_we} !== 4'b1100) begin failures++; $display("FAIL bp_second_rsp got v=%0b l=%0b e=%0b we=%0b", o_rsp_valid, o_rsp_last, o_rsp_err, o_mem_we); end
         end
         if (c == 21) begin
            checks++;
            if (o_req_ready !== 1'b1) begin failures++; $display("FAIL bp_final_ready got=%0b required=1", o_req_ready); end
         end
         if (c < 21) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_back_to_back;
      do_write(16'h0005, 16'h1234);
      send(1'b0, 16'h0005, 16'h0000, 4'd0);
      capture(2);
      checks++;
      if ({c_a[1], c_v[2], c_e[2], c_d[2]} !== {16'h0005, 1'b1, 1'b0, 16'h1234}) begin
         failures++; $display("FAIL b2b_read got addr=%h v=%0b e=%0b d=%h required 0005 1 0 1234", c_a[1], c_v[2], c_e[2], c_d[2]);
      end
   endtask

   task automatic test_reset_mid_burst;
      send(1'b0, 16'h0020, 16'h0000, 4'd3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if ({o_rsp_valid, o_rsp_rdata} !== {1'b1, 16'h2222}) begin failures++; $display("FAIL mid_beat2 got v=%0b d=%h required 1 2222", o_rsp_valid, o_rsp_rdata); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({o_req_ready, o_rsp_valid, o_rsp_last, o_rsp_err, o_rsp_rdata, o_mem_addr, o_mem_wdata, o_mem_we} !== 53'd0) begin
         failures++; $display("FAIL mid_reset_outputs got v=%0b d=%h addr=%h wdata=%h", o_rsp_valid, o_rsp_rdata, o_mem_addr, o_mem_wdata);
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if ({o_rsp_valid, o_req_ready} !== 2'b00) begin failures++; $display("FAIL mid_reset_hold c=%0d got v=%0b r=%0b", c, o_rsp_valid, o_req_ready); end
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (o_req_ready !== 1'b0) begin failures++; $display("FAIL mid_release_ready got=%0b required=0", o_req_ready); end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if ({o_req_ready, o_rsp_valid} !== 2'b10) begin failures++; $display("FAIL mid_after_release c=%0d got r=%0b v=%0b", c, o_req_ready, o_rsp_valid); end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) exp_mem[i] = 16'd0;
      test_reset;
      test_write_read;
      test_burst;
      test_range;
      test_backpressure;
      test_back_to_back;
      test_reset_mid_burst;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store initiator for the 256-word synchronous memory: accepts single-word write and 1–16 word burst read requests from the core over a valid/ready handshake, drives the memory address/data/write-enable port, and returns read data aligned to the memory's one-cycle read latency. Sits between the processor datapath and the memory. Range-checks every request and returns an error response instead of touching memory when out of range.

## Interface
- MEM_WORDS, 256: number of addressable 16-bit words; valid addresses 0..MEM_WORDS-1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  16  word start address.
- req_wdata  in  16  write data (writes only).
- req_len  in  4  burst length minus 1 (reads only; ignored for writes, which are always 1 word).
- rsp_valid  out  1  response beat valid; single-cycle pulse per beat; no backpressure.
- rsp_rdata  out  16  read data for the beat; 0 for write and error responses.
- rsp_last  out  1  final beat of the current request.
- rsp_err  out  1  request rejected (range error); only with rsp_valid.
- mem_addr  out  16  memory word address.
- mem_wdata  out  16  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  16  memory read data; valid the cycle after mem_addr is presented.

## Operation
- States: IDLE, READ, WRITE, ERR, DRAIN.
- A request is accepted on an edge where req_valid && req_ready. req_ready is registered and is 1 only in IDLE.
- Range check at acceptance, computed 17 bits wide: a request fails if req_addr + (req_we ? 0 : req_len) ≥ MEM_WORDS. A failing request → ERR, with no memory access.
- ERR: one cycle with rsp_valid=1, rsp_err=1, rsp_last=1, rsp_rdata=0, mem_we=0. Then IDLE.
- WRITE: one cycle with mem_we=1, mem_addr=req_addr, mem_wdata=req_wdata. The next cycle (DRAIN) carries rsp_valid=1, rsp_last=1, rsp_rdata=0. Then IDLE.
- READ: issue L=req_len+1 addresses on consecutive cycles, base+0 .. base+L-1, using an issue counter.
  - A one-cycle-delayed issue flag generates rsp_valid. rsp_rdata passes mem_rdata through combinationally when the beat is a read, otherwise 0.
  - rsp_last accompanies beat L-1.
  - After the last issue the block sits in DRAIN for the final response, then returns to IDLE.
- mem_we is 0 outside WRITE. mem_addr and mem_wdata hold their last values when idle.
- rsp_err is never asserted together with read data.
- A request held on req_valid while req_ready=0 is not accepted and not corrupted.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, and req_ready, rsp_valid, rsp_last, rsp_err, rsp_rdata, mem_addr, mem_wdata, mem_we all 0. Any in-flight burst is dropped with no further beats. req_ready rises after the first clock edge following rst_n deassertion.
- Accept edge = E0.
- Read of L words:
  - mem_addr=base+k in cycle k+1 after E0.
  - rsp_valid in cycles 2..L+1 after E0.
  - req_ready=1 again in cycle L+2.
- Write: mem_we in cycle 1, rsp in cycle 2, req_ready=1 in cycle 3.
- Error: rsp in cycle 1, req_ready=1 in cycle 2.
- A read issued immediately after a write to the same address returns the new data, because the memory write completes at E1 of the write, before the read issue.

## Test plan
- Reset mid-burst: assert rst_n low during beat 2 of a 4-word read → all outputs 0 immediately, no further rsp_valid; req_ready=1 one edge after release.
- Write then read: write 0xBEEF to 0x0010, then read 0x0010 with len 0 → mem_we exactly one cycle; read rsp_valid exactly 2 cycles after accept with rsp_rdata=0xBEEF, rsp_last=1, rsp_err=0.
- Burst read: preload 0x0020..0x0023 with 0x1111/0x2222/0x3333/0x4444, request addr 0x0020, len 3 → mem_addr steps 0x20..0x23, four consecutive rsp_valid beats carry those values, rsp_last only on the 4th.
- Range boundary:
  - Read 0x00FC len 3 → success with 4 beats.
  - Read 0x00FD len 3 → single beat with rsp_err=1, rsp_last=1, no mem_we, mem_addr unchanged.
  - Read 0xFFFF len 15 → error, with no 16-bit wrap.
  - Write 0x00FF → success.
  - Write 0x0100 → error.
- Backpressure: hold req_valid high with a second request during a 16-word burst → not accepted until req_ready returns in cycle 18; it is then accepted on that edge with its original fields.
- Back-to-back: write 0x1234 to 0x0005, then immediately read 0x0005 on the first req_ready → rsp_rdata=0x1234.
